// File: rtl/scan_ctrl.sv
// scan_ctrl: job sequencer for the SET datapath.
// Accepts scan jobs on en_i, walks each job through clear (START),
// accumulate (BUSY) and report (DONE), and holds at most one further job
// in a pending slot so jobs can run back to back without idle cycles.
module scan_ctrl #(
   parameter int SCAN_LEN = 17,
   parameter int CNT_W    = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             stall_i,
   input  logic             abort_i,
   output logic             ready_o,
   output logic             buffer_en_o,
   output logic             drop_o,
   output logic             coord_en_o,
   output logic             acc_clear_o,
   output logic             acc_en_o,
   output logic [CNT_W-1:0] cycle_o,
   output logic             busy_o,
   output logic             valid_o,
   output logic             clear_o
);

   // One extra bit so a length equal to 2^CNT_W still fits in len_q.
   localparam int LEN_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               pend_q, pend_d;
   logic [CNT_W-1:0]   pend_len_q, pend_len_d;

   // Registered decodes of the next state, so the datapath strobes come
   // straight from flops.
   logic               busy_q;
   logic               start_q;
   logic               run_q;
   logic               done_q;

   logic               accept;
   logic               last_idx;

   // A requested length of zero selects the default scan length.
   function automatic logic [LEN_W-1:0] map_len(input logic [CNT_W-1:0] len);
      if (len == '0) begin
         return LEN_W'(SCAN_LEN);
      end
      return {1'b0, len};
   endfunction

   // Request handshake: a job is accepted whenever the pending slot is empty.
   assign ready_o     = ~pend_q;
   assign accept      = en_i & ready_o;
   assign buffer_en_o = accept;
   assign drop_o      = en_i & ~ready_o;

   assign last_idx = ({1'b0, cnt_q} == (len_q - LEN_W'(1)));

   // Next-state, counter, length and pending-slot logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      pend_d     = pend_q;
      pend_len_d = pend_len_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            // A queued job always wins; ready_o is low while one is queued,
            // so a new request cannot collide with it here.
            if (pend_q) begin
               state_d = S_START;
               len_d   = map_len(pend_len_q);
               pend_d  = 1'b0;
               cnt_d   = '0;
            end else if (accept) begin
               state_d = S_START;
               len_d   = map_len(len_i);
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (accept) begin
               pend_d     = 1'b1;
               pend_len_d = len_i;
            end
            state_d = abort_i ? S_IDLE : S_BUSY;
         end
         S_BUSY: begin
            if (accept) begin
               pend_d     = 1'b1;
               pend_len_d = len_i;
            end
            // abort beats stall, stall beats the counter
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (!stall_i) begin
               if (last_idx) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Controller state and registered output decodes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= LEN_W'(SCAN_LEN);
         pend_q     <= 1'b0;
         pend_len_q <= '0;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
         run_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         pend_q     <= pend_d;
         pend_len_q <= pend_len_d;
         busy_q     <= (state_d == S_START) || (state_d == S_BUSY);
         start_q    <= (state_d == S_START);
         run_q      <= (state_d == S_BUSY);
         done_q     <= (state_d == S_DONE);
      end
   end

   assign busy_o      = busy_q;
   assign coord_en_o  = start_q;
   assign acc_clear_o = start_q;
   assign acc_en_o    = run_q & ~stall_i & ~abort_i;
   assign valid_o     = done_q;
   assign clear_o     = done_q;
   assign cycle_o     = cnt_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: directed scenarios plus a random run,
// all checked cycle by cycle against a job-position reference model.
module tb_scan_ctrl;

   localparam int SCAN_LEN = 17;
   localparam int CNT_W    = 5;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             en_i;
   logic [CNT_W-1:0] len_i;
   logic             stall_i;
   logic             abort_i;
   logic             ready_o, buffer_en_o, drop_o, coord_en_o, acc_clear_o;
   logic             acc_en_o, busy_o, valid_o, clear_o;
   logic [CNT_W-1:0] cycle_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: pos = -1 when no job, 0 for the clear cycle,
   // 1..L for the accumulate cycles (index pos-1), L+1 for the report cycle.
   int pos  = -1;
   int curL = SCAN_LEN;
   int pq[$];

   // Per-scenario observations
   int tcyc, nvalid, nacc, nbusy, firstv, lastv;

   scan_ctrl #(.SCAN_LEN(SCAN_LEN), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .len_i(len_i),
      .stall_i(stall_i), .abort_i(abort_i), .ready_o(ready_o),
      .buffer_en_o(buffer_en_o), .drop_o(drop_o), .coord_en_o(coord_en_o),
      .acc_clear_o(acc_clear_o), .acc_en_o(acc_en_o), .cycle_o(cycle_o),
      .busy_o(busy_o), .valid_o(valid_o), .clear_o(clear_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int eff_len(input int len);
      return (len == 0) ? SCAN_LEN : len;
   endfunction

   task automatic model_reset();
      pos  = -1;
      curL = SCAN_LEN;
      pq.delete();
   endtask

   // Advance the model by one clock edge.
   task automatic model_step(input logic en, input int len, input logic st, input logic ab);
      bit acc;
      acc = en && (pq.size() == 0);
      if (pos < 0 || pos == curL + 1) begin
         if (pq.size() != 0) begin
            curL = pq.pop_front();
            pos  = 0;
         end else if (acc) begin
            curL = eff_len(len);
            pos  = 0;
         end else begin
            pos = -1;
         end
      end else begin
         if (acc) pq.push_back(eff_len(len));
         if (ab)                     pos = -1;
         else if (pos == 0 || !st)   pos = pos + 1;
      end
   endtask

   task automatic compare_all(input logic en, input logic st, input logic ab);
      bit inbusy, rdy;
      rdy    = (pq.size() == 0);
      inbusy = (pos >= 1) && (pos <= curL);
      chk("ready_o",     ready_o,     rdy);
      chk("buffer_en_o", buffer_en_o, en && rdy);
      chk("drop_o",      drop_o,      en && !rdy);
      chk("busy_o",      busy_o,      (pos >= 0) && (pos <= curL));
      chk("coord_en_o",  coord_en_o,  pos == 0);
      chk("acc_clear_o", acc_clear_o, pos == 0);
      chk("acc_en_o",    acc_en_o,    inbusy && !st && !ab);
      chk("valid_o",     valid_o,     pos == curL + 1);
      chk("clear_o",     clear_o,     pos == curL + 1);
      if (pos == 0) chk("cycle_o_start", cycle_o, 0);
      if (inbusy)   chk("cycle_o_busy",  cycle_o, pos - 1);
   endtask

   // One clock cycle: drive, check mid-cycle, advance model at the edge.
   task automatic step(input logic en, input int len, input logic st, input logic ab);
      en_i    = en;
      len_i   = CNT_W'(len);
      stall_i = st;
      abort_i = ab;
      @(negedge clk_i);
      compare_all(en, st, ab);
      if (valid_o === 1'b1) begin
         nvalid++;
         if (firstv < 0) firstv = tcyc;
         lastv = tcyc;
      end
      if (acc_en_o === 1'b1) nacc++;
      if (busy_o === 1'b1)   nbusy++;
      @(posedge clk_i);
      model_step(en, len, st, ab);
      tcyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic begin_test();
      tcyc = 0; nvalid = 0; nacc = 0; nbusy = 0; firstv = -1; lastv = -1;
   endtask

   initial begin
      rst_i = 1'b1; en_i = 1'b0; len_i = '0; stall_i = 1'b0; abort_i = 1'b0;
      model_reset();
      #3;
      chk("rst_ready",   ready_o, 1);
      chk("rst_busy",    busy_o, 0);
      chk("rst_valid",   valid_o, 0);
      chk("rst_cycle",   cycle_o, 0);
      chk("rst_coord",   coord_en_o, 0);
      chk("rst_buf_en0", buffer_en_o, 0);
      en_i = 1'b1;
      #1;
      chk("rst_buf_en1", buffer_en_o, 1);
      chk("rst_drop",    drop_o, 0);
      en_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Default-length job
      begin_test();
      step(1'b1, 0, 1'b0, 1'b0);
      idle(22);
      chk("t1_valid_cycle", firstv, 19);
      chk("t1_valid_count", nvalid, 1);
      chk("t1_acc_count",   nacc, 17);
      chk("t1_busy_count",  nbusy, 18);

      // Short job with a two-cycle stall
      begin_test();
      step(1'b1, 3, 1'b0, 1'b0);
      idle(2);
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      idle(8);
      chk("t2_valid_cycle", firstv, 7);
      chk("t2_acc_count",   nacc, 3);

      // Back-to-back via the pending slot, third request dropped
      begin_test();
      step(1'b1, 4, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 5, 1'b0, 1'b0);
      chk("t3_ready_after_pend", ready_o, 0);
      step(1'b1, 7, 1'b0, 1'b0);
      idle(14);
      chk("t3_first_valid", firstv, 6);
      chk("t3_last_valid",  lastv, 13);
      chk("t3_valid_count", nvalid, 2);
      chk("t3_acc_count",   nacc, 9);

      // Abort with nothing pending
      begin_test();
      step(1'b1, 6, 1'b0, 1'b0);
      idle(3);
      step(1'b0, 0, 1'b0, 1'b1);
      chk("t4a_busy_after_abort", busy_o, 0);
      idle(10);
      chk("t4a_valid_count", nvalid, 0);
      chk("t4a_acc_count",   nacc, 2);

      // Abort with a job pending: pending job starts after one idle cycle
      begin_test();
      step(1'b1, 6, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 2, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 0, 1'b0, 1'b1);
      idle(10);
      chk("t4b_valid_cycle", firstv, 9);
      chk("t4b_valid_count", nvalid, 1);
      chk("t4b_acc_count",   nacc, 4);

      // Asynchronous reset mid-job with a job pending
      begin_test();
      step(1'b1, 8, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 3, 1'b0, 1'b0);
      idle(1);
      en_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("t5_busy",   busy_o, 0);
      chk("t5_ready",  ready_o, 1);
      chk("t5_acc_en", acc_en_o, 0);
      chk("t5_valid",  valid_o, 0);
      chk("t5_clear",  clear_o, 0);
      chk("t5_coord",  coord_en_o, 0);
      chk("t5_cycle",  cycle_o, 0);
      chk("t5_drop",   drop_o, 0);
      model_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      begin_test();
      idle(20);
      chk("t5_no_valid", nvalid, 0);
      chk("t5_no_busy",  nbusy, 0);

      // Request in the DONE cycle starts directly with the new length
      begin_test();
      step(1'b1, 2, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 3, 1'b0, 1'b0);
      idle(10);
      chk("t6_first_valid", firstv, 4);
      chk("t6_last_valid",  lastv, 9);
      chk("t6_valid_count", nvalid, 2);

      // Random traffic against the model
      begin_test();
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4) == 0, int'($urandom_range(0, 6)),
              ($urandom % 6) == 0, ($urandom % 25) == 0);
      end
      idle(25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Parametrised job controller for the SET datapath: accepts scan jobs on a request strobe, sequences clear/load/accumulate/report phases, and raises a one-cycle result-valid. Next-generation controller adding a runtime scan length, a one-deep pending-job slot for back-to-back operation, accumulator stall, and abort. It sits between the top-level input interface and the shadow/working buffers, coordinate generator and accumulator.

## Interface
- SCAN_LEN, 17: BUSY cycles used when a job's len_i is 0.
- CNT_W, 5: counter and length width; 2^CNT_W ≥ SCAN_LEN required.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous and active-high.
- en_i  in  1  job request strobe, one cycle per job.
- len_i  in  CNT_W  scan length for the requesting job, sampled with en_i; 0 selects SCAN_LEN.
- stall_i  in  1  freezes the BUSY counter; effective only in BUSY.
- abort_i  in  1  cancels the running job; effective only in START/BUSY.
- ready_o  out  1  pending slot empty; a request is accepted now.
- buffer_en_o  out  1  load shadow input buffer; en_i & ready_o.
- drop_o  out  1  request rejected; en_i & ~ready_o.
- coord_en_o  out  1  copy shadow buffer to working registers and restart the coordinate generator.
- acc_clear_o  out  1  clear accumulator.
- acc_en_o  out  1  accumulate this cycle.
- cycle_o  out  CNT_W  current BUSY index, 0..L-1.
- busy_o  out  1  job in START or BUSY.
- valid_o  out  1  accumulator holds a completed result.
- clear_o  out  1  end-of-job clear to the datapath.

## Operation
- States: IDLE, START, BUSY, DONE. Registers: state, cnt_q, len_q (active length L), pend_q, pend_len_q.
- IDLE→START when en_i (accepted direct) or pend_q; else hold.
- START→BUSY unconditionally, unless abort_i→IDLE.
- BUSY: abort_i→IDLE, no valid. Else if ~stall_i and cnt_q == L-1→DONE. Else hold; cnt_q increments only when ~stall_i.
- DONE→START if pend_q or en_i accepted; else IDLE.
- Direct acceptance: en_i & ready_o in IDLE or DONE. len_i→len_q at that edge; pend_q unchanged.
- Pending acceptance: en_i & ready_o in START or BUSY. pend_q←1, len_i→pend_len_q.
- On any transition into START from pend_q: len_q←pend_len_q, pend_q←0. If en_i is also accepted in that cycle, it is direct only when pend_q=0; ready_o is 0 when pend_q=1, so no collision.
- cnt_q←0 on entering START; cycle_o = cnt_q.
- Length mapping: L = len_i, or SCAN_LEN when len_i=0. Compare at CNT_W width, no wrap.
- Decoded outputs: busy_o = START|BUSY; acc_clear_o = coord_en_o = START; acc_en_o = BUSY & ~stall_i & ~abort_i; valid_o = clear_o = DONE.
- Abort priority: abort_i > stall_i > counter. A pending job survives an abort: IDLE then START on the next edge.

## Timing
- Reset values (async): state IDLE, cnt_q 0, len_q SCAN_LEN, pend_q 0, pend_len_q 0.
- Reset output values: all outputs 0, except ready_o=1 and buffer_en_o=en_i.
- ready_o, buffer_en_o, drop_o, acc_en_o are combinational. All other outputs decode registered state.
- Latency, unstalled: en_i sampled at edge 0 → START cycle 1 → BUSY cycles 2..L+1 → valid_o in cycle L+2. Default case: valid_o in cycle 19.
- Each stall cycle in BUSY adds one cycle to the job.
- Back-to-back throughput: L+2 cycles per job; DONE goes directly to START.
- Reset mid-job clears the pending job and any partial result; no valid_o.

## Test plan
- Single job, len_i=0, no stall: en_i at cycle 0 → busy_o cycles 1-18, acc_en_o for 17 cycles with cycle_o 0..16, valid_o and clear_o only in cycle 19, then IDLE.
- len_i=3, stall_i high for 2 cycles mid-BUSY: acc_en_o for exactly 3 cycles, cycle_o frozen while stalled, valid_o in cycle 7.
- Second en_i (len 5) during BUSY of the first job (len 4): accepted, ready_o low after it. Third en_i while pend_q=1: drop_o=1, buffer_en_o=0. First job's DONE is followed directly by START, with a second valid_o 7 cycles later.
- abort_i in BUSY with cnt_q=2: next cycle IDLE, no valid_o. With a job pending: START the following cycle using pend_len_q.
- rst_i asserted mid-BUSY with a pending job: all outputs immediately 0, ready_o=1. After release, no activity without en_i.
- en_i in the DONE cycle with pending empty: accepted directly; START follows DONE with the new length.
